// File: rtl/uart_tx_drain_if.sv
// FIFO read-side handshake between the TX FIFO and the serialiser.
// master = the draining serialiser, slave = the FIFO providing words.
interface uart_tx_drain_if #(
    parameter int WIDTH = 8
);
    logic             fifo_empty;
    logic [WIDTH-1:0] fifo_data;
    logic             fifo_pop;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_pop
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_pop
    );
endinterface

// File: rtl/uart_tx_drain.sv
// UART transmitter that drains words from a FIFO read port and sends each
// as a start bit, WIDTH data bits (LSB first) and STOP_BITS stop bits.
module uart_tx_drain #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 8,
    parameter int STOP_BITS    = 1
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            enable,
    uart_tx_drain_if.master fifo,
    output logic            tx,
    output logic            busy,
    output logic            tx_done
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = (WIDTH > 0) ? $clog2(WIDTH + 1) : 1;

    localparam logic [CNT_W-1:0] CLK_LAST   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CLK_PENULT = CNT_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        START,
        DATA,
        STOP
    } state_t;

    state_t             state_reg, state_next;
    logic [CNT_W-1:0]   clk_cnt_reg, clk_cnt_next;
    logic [BIT_W-1:0]   bit_cnt_reg, bit_cnt_next;
    logic [WIDTH-1:0]   shift_reg, shift_next;
    logic               pop_reg, pop_next;
    logic               tx_reg, tx_next;
    logic               busy_reg, busy_next;
    logic               done_reg, done_next;
    logic               clk_wrap;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= IDLE;
            clk_cnt_reg <= '0;
            bit_cnt_reg <= '0;
            shift_reg   <= '0;
            pop_reg     <= 1'b0;
            tx_reg      <= 1'b1;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clk_cnt_reg <= clk_cnt_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            pop_reg     <= pop_next;
            tx_reg      <= tx_next;
            busy_reg    <= busy_next;
            done_reg    <= done_next;
        end
    end

    // Every output is a flop, so each *_next value describes the coming cycle.
    always_comb begin
        state_next   = state_reg;
        clk_cnt_next = clk_cnt_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        pop_next     = 1'b0;
        tx_next      = 1'b1;
        done_next    = 1'b0;
        clk_wrap     = (clk_cnt_reg == CLK_LAST);

        case (state_reg)
            IDLE: begin
                // The pop strobe is already on the wire this cycle; data follows next cycle.
                if (pop_reg) begin
                    state_next = FETCH;
                end else if (enable && !fifo.fifo_empty) begin
                    pop_next = 1'b1;
                end
            end
            FETCH: begin
                shift_next   = fifo.fifo_data;
                clk_cnt_next = '0;
                tx_next      = 1'b0;
                state_next   = START;
            end
            START: begin
                tx_next      = 1'b0;
                clk_cnt_next = clk_wrap ? '0 : clk_cnt_reg + 1'b1;
                if (clk_wrap) begin
                    state_next   = DATA;
                    bit_cnt_next = '0;
                    tx_next      = shift_reg[0];
                end
            end
            DATA: begin
                tx_next      = shift_reg[0];
                clk_cnt_next = clk_wrap ? '0 : clk_cnt_reg + 1'b1;
                if (clk_wrap) begin
                    if (bit_cnt_reg == BIT_LAST) begin
                        state_next   = STOP;
                        bit_cnt_next = '0;
                        tx_next      = 1'b1;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        shift_next   = shift_reg >> 1;
                        tx_next      = shift_next[0];
                    end
                end
            end
            STOP: begin
                tx_next      = 1'b1;
                clk_cnt_next = clk_wrap ? '0 : clk_cnt_reg + 1'b1;
                if (clk_cnt_reg == CLK_PENULT && bit_cnt_reg == STOP_LAST) begin
                    done_next = 1'b1;
                end
                if (clk_wrap) begin
                    if (bit_cnt_reg == STOP_LAST) begin
                        state_next   = IDLE;
                        bit_cnt_next = '0;
                        // Deciding here lets back-to-back frames pop in the very first idle cycle.
                        pop_next     = enable && !fifo.fifo_empty;
                    end else begin
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
    end

    assign fifo.fifo_pop = pop_reg;
    assign tx            = tx_reg;
    assign busy          = busy_reg;
    assign tx_done       = done_reg;
endmodule
